// File: rtl/ppu_pkg.sv
// Shared types and constants for the PPU colour output stage:
// RGB struct, emphasis type, pixel position tag and the 2C02 RGB888 palette.
package ppu_pkg;

    localparam int PPU_H_ACTIVE = 256;
    localparam int PPU_V_ACTIVE = 240;
    localparam int PPU_RGB_W    = 8;

    typedef struct packed {
        logic [PPU_RGB_W-1:0] r;
        logic [PPU_RGB_W-1:0] g;
        logic [PPU_RGB_W-1:0] b;
    } rgb_t;

    // PPUMASK bits 7:5, ordered {B,G,R}
    typedef logic [2:0] emph_t;

    typedef struct packed {
        logic [8:0] x;
        logic [7:0] y;
        logic       sof;
        logic       eol;
        logic       eof;
    } pix_tag_t;

    localparam logic [23:0] NES_PAL_ROM [64] = '{
        24'h666666, 24'h002A88, 24'h1412A7, 24'h3B00A4, 24'h5C007E, 24'h6E0040, 24'h6C0600, 24'h561D00,
        24'h333500, 24'h0B4800, 24'h005200, 24'h004F08, 24'h00404D, 24'h000000, 24'h000000, 24'h000000,
        24'hADADAD, 24'h155FD9, 24'h4240FF, 24'h7527FE, 24'hA01ACC, 24'hB71E7B, 24'hB53120, 24'h994E00,
        24'h6B6D00, 24'h388700, 24'h0C9300, 24'h008F32, 24'h007C8D, 24'h000000, 24'h000000, 24'h000000,
        24'hFFFEFF, 24'h64B0FF, 24'h9290FF, 24'hC676FF, 24'hF36AFF, 24'hFE6ECC, 24'hFE8170, 24'hEA9E22,
        24'hBCBE00, 24'h88D800, 24'h5CE430, 24'h45E082, 24'h48CDDE, 24'h4F4F4F, 24'h000000, 24'h000000,
        24'hFFFEFF, 24'hC0DFFF, 24'hD3D2FF, 24'hE8C8FF, 24'hFBC2FF, 24'hFEC4EA, 24'hFECCC5, 24'hF7D8A5,
        24'hE4E594, 24'hCFEF96, 24'hBDF4AB, 24'hB3F3CC, 24'hB5EBF2, 24'hB8B8B8, 24'h000000, 24'h000000
    };

endpackage

// File: rtl/ppu_rgb_rom.sv
// 64-entry colour ROM with registered read; RGB888 palette entries are
// rescaled to RGB_W bits per channel (MSB-aligned).
module ppu_rgb_rom
    import ppu_pkg::*;
#(
    parameter int RGB_W = PPU_RGB_W
) (
    input  logic               clk,
    input  logic [5:0]         addr_i,
    output logic [3*RGB_W-1:0] data_o
);

    function automatic logic [RGB_W-1:0] scale8(input logic [7:0] c);
        return RGB_W'({c, {RGB_W{1'b0}}} >> 8);
    endfunction

    logic [3*RGB_W-1:0] rom_mem [64];
    logic [3*RGB_W-1:0] data_q;

    for (genvar gi = 0; gi < 64; gi++) begin : g_entry
        rgb_t pal;
        assign pal         = rgb_t'(NES_PAL_ROM[gi]);
        assign rom_mem[gi] = {scale8(pal.r), scale8(pal.g), scale8(pal.b)};
    end

    always_ff @(posedge clk) begin
        data_q <= rom_mem[addr_i];
    end

    assign data_o = data_q;

endmodule

// File: rtl/ppu_color_out.sv
// PPU video output stage: grayscale, palette ROM lookup, optional colour
// emphasis (macro PPU_EMPHASIS_EN) and x/y/sof/eol/eof tagging; 3-cycle latency.
module ppu_color_out
    import ppu_pkg::*;
#(
    parameter int H_ACTIVE = PPU_H_ACTIVE,
    parameter int V_ACTIVE = PPU_V_ACTIVE,
    parameter int RGB_W    = PPU_RGB_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_start_i,
    input  logic               pix_valid_i,
    input  logic [5:0]         pix_color_i,
    input  logic               grayscale_i,
    input  logic [2:0]         emphasis_i,
    output logic               rgb_valid_o,
    output logic [3*RGB_W-1:0] rgb_o,
    output logic [8:0]         x_o,
    output logic [7:0]         y_o,
    output logic               sof_o,
    output logic               eol_o,
    output logic               eof_o
);

    localparam logic [8:0] X_LAST = 9'(H_ACTIVE - 1);
    localparam logic [7:0] Y_LAST = 8'(V_ACTIVE - 1);

    logic [8:0]         x_q, x_d;
    logic [7:0]         y_q, y_d;
    pix_tag_t           tag_d;
    logic [5:0]         idx_d;
    logic               s0_valid_q, s1_valid_q, out_valid_q;
    logic [5:0]         s0_idx_q;
    pix_tag_t           s0_tag_q, s1_tag_q, out_tag_q;
    logic [3*RGB_W-1:0] rom_rgb, emph_rgb, out_rgb_q;

    // A coincident frame_start_i forces the current pixel to (0,0).
    always_comb begin
        tag_d.x   = frame_start_i ? 9'd0 : x_q;
        tag_d.y   = frame_start_i ? 8'd0 : y_q;
        tag_d.sof = (tag_d.x == 9'd0) && (tag_d.y == 8'd0);
        tag_d.eol = (tag_d.x == X_LAST);
        tag_d.eof = tag_d.eol && (tag_d.y == Y_LAST);
        x_d       = tag_d.x;
        y_d       = tag_d.y;
        if (pix_valid_i) begin
            if (tag_d.eol) begin
                x_d = 9'd0;
                y_d = tag_d.eof ? 8'd0 : tag_d.y + 8'd1;
            end else begin
                x_d = tag_d.x + 9'd1;
            end
        end
        idx_d = grayscale_i ? (pix_color_i & 6'h30) : pix_color_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q        <= '0;
            y_q        <= '0;
            s0_valid_q <= 1'b0;
            s0_idx_q   <= '0;
            s0_tag_q   <= '0;
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            s0_valid_q <= pix_valid_i;
            if (pix_valid_i) begin
                s0_idx_q <= idx_d;
                s0_tag_q <= tag_d;
            end
        end
    end

    ppu_rgb_rom #(.RGB_W(RGB_W)) u_rom (
        .clk    (clk),
        .addr_i (s0_idx_q),
        .data_o (rom_rgb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_tag_q   <= '0;
        end else begin
            s1_valid_q <= s0_valid_q;
            if (s0_valid_q) begin
                s1_tag_q <= s0_tag_q;
            end
        end
    end

`ifdef PPU_EMPHASIS_EN
    emph_t s0_emph_q, s1_emph_q;
    logic  s1_dark_q;
    logic  emph_act;

    // Columns $E/$F are black and never attenuated.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_emph_q <= '0;
            s1_emph_q <= '0;
            s1_dark_q <= 1'b0;
        end else begin
            if (pix_valid_i) begin
                s0_emph_q <= emphasis_i;
            end
            if (s0_valid_q) begin
                s1_emph_q <= s0_emph_q;
                s1_dark_q <= (s0_idx_q[3:1] == 3'b111);
            end
        end
    end

    assign emph_act = (s1_emph_q != 3'b000) && !s1_dark_q;

    // Slot 0 is blue, slot 2 red, while emphasis bits run {B,G,R}.
    for (genvar gi = 0; gi < 3; gi++) begin : g_emph
        logic [RGB_W-1:0] chan;
        assign chan = rom_rgb[gi*RGB_W +: RGB_W];
        assign emph_rgb[gi*RGB_W +: RGB_W] =
            (emph_act && !s1_emph_q[2-gi]) ? chan - (chan >> 2) : chan;
    end
`else
    logic emph_unused;
    assign emph_unused = ^emphasis_i;
    assign emph_rgb    = rom_rgb;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_rgb_q   <= '0;
            out_tag_q   <= '0;
        end else begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_rgb_q <= emph_rgb;
                out_tag_q <= s1_tag_q;
            end
        end
    end

    assign rgb_valid_o = out_valid_q;
    assign rgb_o       = out_rgb_q;
    assign x_o         = out_tag_q.x;
    assign y_o         = out_tag_q.y;
    assign sof_o       = out_tag_q.sof & out_valid_q;
    assign eol_o       = out_tag_q.eol & out_valid_q;
    assign eof_o       = out_tag_q.eof & out_valid_q;

endmodule

// File: tb/tb_ppu_color_out.sv
// Self-checking bench for ppu_color_out: literal vector table, randomized
// stream against a pixel-numbering reference model, geometry and resync sequences.
module tb_ppu_color_out;
    import ppu_pkg::*;

    localparam int H = 256;
    localparam int V = 240;
`ifdef PPU_EMPHASIS_EN
    localparam bit EMPH_ON = 1'b1;
`else
    localparam bit EMPH_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start_i;
    logic        pix_valid_i;
    logic [5:0]  pix_color_i;
    logic        grayscale_i;
    logic [2:0]  emphasis_i;
    logic        rgb_valid_o;
    logic [23:0] rgb_o;
    logic [8:0]  x_o;
    logic [7:0]  y_o;
    logic        sof_o, eol_o, eof_o;

    ppu_color_out dut (
        .clk           (clk),
        .rst           (rst),
        .frame_start_i (frame_start_i),
        .pix_valid_i   (pix_valid_i),
        .pix_color_i   (pix_color_i),
        .grayscale_i   (grayscale_i),
        .emphasis_i    (emphasis_i),
        .rgb_valid_o   (rgb_valid_o),
        .rgb_o         (rgb_o),
        .x_o           (x_o),
        .y_o           (y_o),
        .sof_o         (sof_o),
        .eol_o         (eol_o),
        .eof_o         (eof_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  c;
        bit          gs;
        logic [2:0]  em;
        logic [23:0] lit;
    } vec_t;

    typedef struct {
        int          due;
        logic [23:0] rgb;
        logic [23:0] lit;
        bit          has_lit;
        int          x;
        int          y;
        bit          sof, eol, eof;
    } exp_t;

    exp_t        expq[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          n_pix = 0;
    bit          mon_en = 1'b0;
    bit          cur_has_lit = 1'b0;
    logic [23:0] cur_lit = '0;
    logic [23:0] last_rgb = '0;
    int          last_x = 0;
    int          last_y = 0;
    int          eol_seen = 0;
    int          eof_seen = 0;
    int          sof_seen = 0;

    // Reference colour: grayscale keeps the palette row, emphasis scales the
    // non-emphasised channels by c - floor(c/4) except in columns $E/$F.
    function automatic logic [23:0] ref_rgb(input int color, input bit gs, input int em);
        int          idx;
        int          ch [3];
        logic [23:0] p;
        idx   = gs ? (color / 16) * 16 : color;
        p     = NES_PAL_ROM[idx];
        ch[0] = int'(p[23:16]);
        ch[1] = int'(p[15:8]);
        ch[2] = int'(p[7:0]);
        if (EMPH_ON && em != 0 && (idx % 16) < 14) begin
            for (int k = 0; k < 3; k++) begin
                if (((em >> k) & 1) == 0) ch[k] = ch[k] - ch[k] / 4;
            end
        end
        return {8'(ch[0]), 8'(ch[1]), 8'(ch[2])};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    // Model: pixel numbering since the last frame start; position from plain arithmetic.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                expq.delete();
                n_pix    = 0;
                last_rgb = '0;
                last_x   = 0;
                last_y   = 0;
            end else begin
                if (frame_start_i) n_pix = 0;
                if (pix_valid_i) begin
                    e.due     = cyc + 2;
                    e.rgb     = ref_rgb(int'(pix_color_i), grayscale_i, int'(emphasis_i));
                    e.lit     = cur_lit;
                    e.has_lit = cur_has_lit;
                    e.x       = n_pix % H;
                    e.y       = (n_pix / H) % V;
                    e.sof     = (n_pix % (H * V)) == 0;
                    e.eol     = e.x == H - 1;
                    e.eof     = (n_pix % (H * V)) == H * V - 1;
                    expq.push_back(e);
                    n_pix++;
                end
            end
        end
    end

    // Monitor: one comparison per cycle, pixel or bubble.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                n_checks++;
                if (expq.size() > 0 && expq[0].due == cyc) begin
                    e = expq.pop_front();
                    if (rgb_valid_o !== 1'b1 || rgb_o !== e.rgb || x_o !== 9'(e.x) || y_o !== 8'(e.y) ||
                        sof_o !== e.sof || eol_o !== e.eol || eof_o !== e.eof) begin
                        n_errors++;
                        $display("FAIL pixel: got v=%0b rgb=%06h x=%0d y=%0d sof=%0b eol=%0b eof=%0b, want v=1 rgb=%06h x=%0d y=%0d sof=%0b eol=%0b eof=%0b",
                                 rgb_valid_o, rgb_o, x_o, y_o, sof_o, eol_o, eof_o,
                                 e.rgb, e.x, e.y, e.sof, e.eol, e.eof);
                    end
                    if (e.has_lit) chk("table_rgb", 64'(rgb_o), 64'(e.lit));
                    last_rgb = e.rgb;
                    last_x   = e.x;
                    last_y   = e.y;
                    if (sof_o === 1'b1) sof_seen++;
                    if (eol_o === 1'b1) eol_seen++;
                    if (eof_o === 1'b1) eof_seen++;
                end else begin
                    if (rgb_valid_o !== 1'b0 || sof_o !== 1'b0 || eol_o !== 1'b0 || eof_o !== 1'b0 ||
                        rgb_o !== last_rgb || x_o !== 9'(last_x) || y_o !== 8'(last_y)) begin
                        n_errors++;
                        $display("FAIL bubble: got v=%0b rgb=%06h x=%0d y=%0d flags=%0b%0b%0b, want v=0 rgb=%06h x=%0d y=%0d flags=000",
                                 rgb_valid_o, rgb_o, x_o, y_o, sof_o, eol_o, eof_o, last_rgb, last_x, last_y);
                    end
                end
            end
        end
    end

    task automatic drive(input bit v, input bit fs, input logic [5:0] c, input bit gs, input logic [2:0] em);
        pix_valid_i   = v;
        frame_start_i = fs;
        pix_color_i   = c;
        grayscale_i   = gs;
        emphasis_i    = em;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_rand(input bit fs);
        drive(1'b1, fs, 6'($urandom_range(63)), 1'($urandom_range(1)), 3'($urandom_range(7)));
    endtask

    task automatic drain(input string name);
        int k;
        pix_valid_i   = 1'b0;
        frame_start_i = 1'b0;
        k = 0;
        while (expq.size() != 0 && k < 10) begin
            @(posedge clk);
            #1;
            k++;
        end
        @(posedge clk);
        #1;
        chk(name, 64'(expq.size()), 64'd0);
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [8];
        int   sent;

        tbl[0] = '{6'h0F, 1'b0, 3'b000, 24'h000000};
        tbl[1] = '{6'h30, 1'b0, 3'b000, 24'hFFFEFF};
        tbl[2] = '{6'h16, 1'b0, 3'b000, 24'hB53120};
        tbl[3] = '{6'h16, 1'b1, 3'b000, 24'hADADAD};
        tbl[4] = '{6'h30, 1'b0, 3'b001, EMPH_ON ? 24'hFFBFC0 : 24'hFFFEFF};
        tbl[5] = '{6'h0F, 1'b0, 3'b001, 24'h000000};
        tbl[6] = '{6'h30, 1'b0, 3'b111, 24'hFFFEFF};
        tbl[7] = '{6'h16, 1'b0, 3'b010, EMPH_ON ? 24'h883118 : 24'hB53120};

        // Reset held 4 cycles with a pixel offered every cycle.
        rst           = 1'b1;
        pix_valid_i   = 1'b1;
        frame_start_i = 1'b0;
        pix_color_i   = 6'h21;
        grayscale_i   = 1'b0;
        emphasis_i    = 3'b000;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("reset_outputs", 64'({rgb_valid_o, rgb_o, x_o, y_o, sof_o, eol_o, eof_o}), 64'd0);
        rst = 1'b0;

        // Table vectors back to back; the first lands at (0,0).
        for (int i = 0; i < 8; i++) begin
            cur_lit     = tbl[i].lit;
            cur_has_lit = 1'b1;
            drive(1'b1, 1'b0, tbl[i].c, tbl[i].gs, tbl[i].em);
        end
        cur_has_lit = 1'b0;
        drive(1'b0, 1'b0, 6'h00, 1'b0, 3'b000);
        drive(1'b0, 1'b0, 6'h00, 1'b0, 3'b000);

        // Short random stream with bubbles and random mask bits.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(3) == 0) drive(1'b0, 1'b0, 6'($urandom_range(63)), 1'b0, 3'b000);
            else drive_rand(1'b0);
        end
        drain("drain_random");

        // Full frame with random bubbles after a standalone frame start.
        eol_seen = 0;
        eof_seen = 0;
        sof_seen = 0;
        drive(1'b0, 1'b1, 6'h00, 1'b0, 3'b000);
        sent = 0;
        while (sent < H * V) begin
            if ($urandom_range(31) == 0) begin
                drive(1'b0, 1'b0, 6'h00, 1'b0, 3'b000);
            end else begin
                drive_rand(1'b0);
                sent++;
            end
        end
        drain("drain_frame");
        chk("frame_sof_count", 64'(sof_seen), 64'd1);
        chk("frame_eol_count", 64'(eol_seen), 64'(V));
        chk("frame_eof_count", 64'(eof_seen), 64'd1);

        // Wrap pixel, then advance to (100,5) and resync with a coincident pixel.
        sof_seen = 0;
        drive_rand(1'b0);
        for (int i = 0; i < 5 * H + 100 - 1; i++) drive_rand(1'b0);
        drain("drain_pre_resync");
        chk("wrap_sof_count", 64'(sof_seen), 64'd1);
        sof_seen = 0;
        eol_seen = 0;
        eof_seen = 0;
        drive_rand(1'b1);
        for (int i = 0; i < 200; i++) drive_rand(1'b0);
        drain("drain_resync");
        chk("resync_sof_count", 64'(sof_seen), 64'd1);
        chk("resync_eol_count", 64'(eol_seen), 64'd0);
        chk("resync_eof_count", 64'(eof_seen), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
